// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I controller.
// States, opcodes, ALUOp and datapath mux select encodings.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    JAL,
    BEQ
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_STORE: imm_src = IMM_S;
      OP_BEQ:   imm_src = IMM_B;
      OP_JAL:   imm_src = IMM_J;
      default:  imm_src = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU control decode for the multicycle controller.
// Maps ALUOp plus funct fields onto the 3-bit ALU operation.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  aluop_t      alu_op,
  input  logic [2:0]  funct3,
  input  logic        op5,
  input  logic        funct7b5,
  output logic [2:0]  alu_control
);

  // funct3 selects the op; sub only for R-type with funct7b5
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM and decoders for a multicycle RV32I-subset datapath.
// Define MCCTRL_PERF_EN to add cycle_o/instret_o performance counters.
module multicycle_controller
  import mc_ctrl_pkg::*;
`ifdef MCCTRL_PERF_EN
#(
  parameter int PERF_WIDTH = 32
)
`endif
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [6:0]  op_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  input  logic        Zero_i,
  input  logic        mem_ready_i,
  output logic        PCWrite_o,
  output logic        AdrSrc_o,
  output logic        MemWrite_o,
  output logic        IRWrite_o,
  output logic [1:0]  ResultSrc_o,
  output logic [2:0]  ALUControl_o,
  output logic [1:0]  ALUSrcA_o,
  output logic [1:0]  ALUSrcB_o,
  output logic [1:0]  ImmSrc_o,
  output logic        RegWrite_o
`ifdef MCCTRL_PERF_EN
  ,
  output logic [PERF_WIDTH-1:0] cycle_o,
  output logic [PERF_WIDTH-1:0] instret_o
`endif
);

  state_t state;
  state_t state_n;
  state_t state_eff;

  aluop_t alu_op;
  logic   pc_update;
  logic   branch;
  logic   ir_write;
  logic   mem_write;
  logic   reg_write;

  // state register; reset lands in FETCH at the edge
  always_ff @(posedge clk_i) begin
    if (reset_i) state <= FETCH;
    else         state <= state_n;
  end

  // next-state sequencing, memory states hold for mem_ready_i
  always_comb begin
    state_n = state;
    case (state)
      FETCH:    if (mem_ready_i) state_n = DECODE;
      DECODE: begin
        case (op_i)
          OP_LOAD,
          OP_STORE: state_n = MEMADR;
          OP_RTYPE: state_n = EXECUTER;
          OP_ITYPE: state_n = EXECUTEI;
          OP_JAL:   state_n = JAL;
          OP_BEQ:   state_n = BEQ;
          default:  state_n = FETCH;
        endcase
      end
      MEMADR:   state_n = op_i[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready_i) state_n = MEMWB;
      MEMWB:    state_n = FETCH;
      MEMWRITE: if (mem_ready_i) state_n = FETCH;
      EXECUTER: state_n = ALUWB;
      EXECUTEI: state_n = ALUWB;
      ALUWB:    state_n = FETCH;
      JAL:      state_n = ALUWB;
      BEQ:      state_n = FETCH;
      default:  state_n = FETCH;
    endcase
  end

  // while in reset the muxes show FETCH settings
  assign state_eff = reset_i ? FETCH : state;

  // per-state datapath controls
  always_comb begin
    AdrSrc_o    = 1'b0;
    ResultSrc_o = RES_ALUOUT;
    ALUSrcA_o   = SRCA_PC;
    ALUSrcB_o   = SRCB_RS2;
    alu_op      = ALUOP_ADD;
    pc_update   = 1'b0;
    branch      = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    case (state_eff)
      FETCH: begin
        ALUSrcB_o   = SRCB_4;
        ResultSrc_o = RES_ALURES;
        ir_write    = mem_ready_i;
        pc_update   = mem_ready_i;
      end
      DECODE: begin
        ALUSrcA_o = SRCA_OLDPC;
        ALUSrcB_o = SRCB_IMM;
      end
      MEMADR: begin
        ALUSrcA_o = SRCA_RS1;
        ALUSrcB_o = SRCB_IMM;
      end
      MEMREAD:  AdrSrc_o = 1'b1;
      MEMWB: begin
        ResultSrc_o = RES_DATA;
        reg_write   = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc_o  = 1'b1;
        mem_write = mem_ready_i;
      end
      EXECUTER: begin
        ALUSrcA_o = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        ALUSrcA_o = SRCA_RS1;
        ALUSrcB_o = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      ALUWB:    reg_write = 1'b1;
      JAL: begin
        ALUSrcA_o = SRCA_OLDPC;
        ALUSrcB_o = SRCB_4;
        pc_update = 1'b1;
      end
      BEQ: begin
        ALUSrcA_o = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWrite_o  = ~reset_i & (pc_update | (branch & Zero_i));
  assign IRWrite_o  = ~reset_i & ir_write;
  assign MemWrite_o = ~reset_i & mem_write;
  assign RegWrite_o = ~reset_i & reg_write;
  assign ImmSrc_o   = imm_src(op_i);

  mc_alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3_i),
    .op5         (op_i[5]),
    .funct7b5    (funct7b5_i),
    .alu_control (ALUControl_o)
  );

`ifdef MCCTRL_PERF_EN
  // cycle and retired-instruction counters
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cycle_o   <= '0;
      instret_o <= '0;
    end else begin
      cycle_o <= cycle_o + PERF_WIDTH'(1);
      if (state != FETCH && state_n == FETCH)
        instret_o <= instret_o + PERF_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-instruction cycle
// scripts push expected controls, a negedge monitor pops and compares.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [6:0]  op_i;
  logic [2:0]  funct3_i;
  logic        funct7b5_i;
  logic        Zero_i;
  logic        mem_ready_i;
  logic        PCWrite_o;
  logic        AdrSrc_o;
  logic        MemWrite_o;
  logic        IRWrite_o;
  logic [1:0]  ResultSrc_o;
  logic [2:0]  ALUControl_o;
  logic [1:0]  ALUSrcA_o;
  logic [1:0]  ALUSrcB_o;
  logic [1:0]  ImmSrc_o;
  logic        RegWrite_o;
`ifdef MCCTRL_PERF_EN
  logic [31:0] cycle_o;
  logic [31:0] instret_o;
`endif

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .op_i         (op_i),
    .funct3_i     (funct3_i),
    .funct7b5_i   (funct7b5_i),
    .Zero_i       (Zero_i),
    .mem_ready_i  (mem_ready_i),
    .PCWrite_o    (PCWrite_o),
    .AdrSrc_o     (AdrSrc_o),
    .MemWrite_o   (MemWrite_o),
    .IRWrite_o    (IRWrite_o),
    .ResultSrc_o  (ResultSrc_o),
    .ALUControl_o (ALUControl_o),
    .ALUSrcA_o    (ALUSrcA_o),
    .ALUSrcB_o    (ALUSrcB_o),
    .ImmSrc_o     (ImmSrc_o),
    .RegWrite_o   (RegWrite_o)
`ifdef MCCTRL_PERF_EN
    ,
    .cycle_o      (cycle_o),
    .instret_o    (instret_o)
`endif
  );

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic [2:0] aluc;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] imm;
    logic       regw;
  } ctl_t;

  typedef struct packed {
    ctl_t        c;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          fails  = 0;
  logic [31:0] m_cyc  = 0;
  logic [31:0] m_ret  = 0;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] JL   = 7'b1101111;
  localparam logic [6:0] BQ   = 7'b1100011;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic ctl_t ctl(logic pcw, logic adr, logic memw, logic irw,
                               logic [1:0] res, logic [2:0] aluc,
                               logic [1:0] srca, logic [1:0] srcb,
                               logic regw);
    ctl_t c;
    c = '{pcw, adr, memw, irw, res, aluc, srca, srcb, 2'b00, regw};
    return c;
  endfunction

  // immediate format the datapath needs for each instruction kind
  function automatic logic [1:0] imm_ref(logic [6:0] op);
    if (op == SW) return 2'b01;
    if (op == BQ) return 2'b10;
    if (op == JL) return 2'b11;
    return 2'b00;
  endfunction

  // ALU operation implied by the instruction mnemonic
  function automatic logic [2:0] alu_ref(logic [6:0] op, logic [2:0] f3,
                                         logic f7);
    case (f3)
      3'b000:  return (op == RT && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // one clock of stimulus with its expected response
  task automatic step(ctl_t c, logic rst, logic rdy, logic z, logic last);
    exp_t e;
    reset_i     = rst;
    mem_ready_i = rdy;
    Zero_i      = z;
    c.imm       = imm_ref(op_i);
    e.c   = c;
    e.cyc = m_cyc;
    e.ret = m_ret;
    sb.push_back(e);
    if (rst) begin
      m_cyc = 0;
      m_ret = 0;
    end else begin
      m_cyc++;
      if (last) m_ret++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle();
    step(ctl(0,0,0,0,2'b10,3'b000,2'b00,2'b10,0), 1'b1, rb(), rb(), 1'b0);
  endtask

  task automatic do_instr(logic [6:0] op, logic [2:0] f3, logic f7,
                          logic z, int fw, int mw, bit abort);
    bit known;
    op_i       = op;
    funct3_i   = f3;
    funct7b5_i = f7;
    known = (op == LW) || (op == SW) || (op == RT) ||
            (op == IT) || (op == JL) || (op == BQ);
    repeat (fw)
      step(ctl(0,0,0,0,2'b10,3'b000,2'b00,2'b10,0), 0, 0, rb(), 0);
    step(ctl(1,0,0,1,2'b10,3'b000,2'b00,2'b10,0), 0, 1, rb(), 0);
    step(ctl(0,0,0,0,2'b00,3'b000,2'b01,2'b01,0), 0, rb(), rb(), !known);
    if (op == LW || op == SW)
      step(ctl(0,0,0,0,2'b00,3'b000,2'b10,2'b01,0), 0, rb(), rb(), 0);
    if (op == LW) begin
      for (int i = 0; i < mw; i++) begin
        step(ctl(0,1,0,0,2'b00,3'b000,2'b00,2'b00,0), 0, 0, rb(), 0);
        if (abort) begin
          reset_cycle();
          return;
        end
      end
      step(ctl(0,1,0,0,2'b00,3'b000,2'b00,2'b00,0), 0, 1, rb(), 0);
      step(ctl(0,0,0,0,2'b01,3'b000,2'b00,2'b00,1), 0, rb(), rb(), 1);
    end else if (op == SW) begin
      repeat (mw)
        step(ctl(0,1,0,0,2'b00,3'b000,2'b00,2'b00,0), 0, 0, rb(), 0);
      step(ctl(0,1,1,0,2'b00,3'b000,2'b00,2'b00,0), 0, 1, rb(), 1);
    end else if (op == RT || op == IT) begin
      step(ctl(0,0,0,0,2'b00,alu_ref(op, f3, f7),2'b10,
               (op == RT) ? 2'b00 : 2'b01,0), 0, rb(), rb(), 0);
      step(ctl(0,0,0,0,2'b00,3'b000,2'b00,2'b00,1), 0, rb(), rb(), 1);
    end else if (op == JL) begin
      step(ctl(1,0,0,0,2'b00,3'b000,2'b01,2'b10,0), 0, rb(), rb(), 0);
      step(ctl(0,0,0,0,2'b00,3'b000,2'b00,2'b00,1), 0, rb(), rb(), 1);
    end else if (op == BQ) begin
      step(ctl(z,0,0,0,2'b00,3'b001,2'b10,2'b00,0), 0, rb(), z, 1);
    end
  endtask

  // monitor: compare every presented cycle against the scoreboard
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      ctl_t a;
      e = sb.pop_front();
      a = '{PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, ResultSrc_o,
            ALUControl_o, ALUSrcA_o, ALUSrcB_o, ImmSrc_o, RegWrite_o};
      checks++;
      if (a !== e.c) begin
        fails++;
        $display("FAIL ctl t=%0t got pcw%b adr%b mw%b ir%b res%b alu%b a%b b%b imm%b rw%b want pcw%b adr%b mw%b ir%b res%b alu%b a%b b%b imm%b rw%b",
                 $time, a.pcw, a.adr, a.memw, a.irw, a.res, a.aluc, a.srca,
                 a.srcb, a.imm, a.regw, e.c.pcw, e.c.adr, e.c.memw, e.c.irw,
                 e.c.res, e.c.aluc, e.c.srca, e.c.srcb, e.c.imm, e.c.regw);
      end
`ifdef MCCTRL_PERF_EN
      checks++;
      if (cycle_o !== e.cyc || instret_o !== e.ret) begin
        fails++;
        $display("FAIL perf t=%0t got cyc=%0d ret=%0d want cyc=%0d ret=%0d",
                 $time, cycle_o, instret_o, e.cyc, e.ret);
      end
`endif
    end
  end

  initial begin
    logic [6:0] others[7];
    others = '{7'b0000000, 7'b0010111, 7'b0110111, 7'b1100111,
               7'b1110011, 7'b0001111, 7'b1111111};
    reset_i     = 1'b1;
    op_i        = RT;
    funct3_i    = 3'b000;
    funct7b5_i  = 1'b1;
    Zero_i      = 1'b0;
    mem_ready_i = 1'b0;
    @(posedge clk);
    #1;
    reset_cycle();
    reset_cycle();

    do_instr(RT, 3'b000, 1'b1, 1'b0, 0, 0, 0);
    do_instr(LW, 3'b010, 1'b0, 1'b0, 0, 3, 0);
    do_instr(SW, 3'b010, 1'b0, 1'b0, 0, 2, 0);
    do_instr(BQ, 3'b000, 1'b0, 1'b1, 0, 0, 0);
    do_instr(BQ, 3'b000, 1'b0, 1'b0, 0, 0, 0);
    do_instr(LW, 3'b010, 1'b0, 1'b0, 0, 2, 1);
    do_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0, 0);
    do_instr(IT, 3'b000, 1'b1, 1'b0, 1, 0, 0);
    do_instr(JL, 3'b000, 1'b0, 1'b0, 0, 0, 0);

    for (int n = 0; n < 200; n++) begin
      logic [6:0] op;
      int k;
      int mw;
      bit ab;
      k = $urandom_range(0, 6);
      case (k)
        0: op = LW;
        1: op = SW;
        2: op = RT;
        3: op = IT;
        4: op = JL;
        5: op = BQ;
        default: op = others[$urandom_range(0, 6)];
      endcase
      mw = $urandom_range(0, 3);
      ab = (op == LW) && (mw > 0) && ($urandom_range(0, 9) == 0);
      do_instr(op, 3'($urandom_range(0, 7)), rb(), rb(),
               $urandom_range(0, 2), mw, ab);
      if ($urandom_range(0, 29) == 0) reset_cycle();
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
